// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter_pkg
// Description : Shared widths and write-request type for the RF write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wr_req_t;

    // Register 0 is hardwired, so it never creates a hazard.
    function automatic logic reg_hit(input logic                  valid,
                                     input logic [REG_ADDR_W-1:0] entry_reg,
                                     input logic [REG_ADDR_W-1:0] query_reg);
        return valid && (query_reg != '0) && (entry_reg == query_reg);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : rf_wr_fifo
// Description : Small FIFO of pending MDU writes, exposing every slot for lookup.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_wr_fifo
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  push,
    input  wr_req_t                               push_req,
    input  logic                                  pop,
    output wr_req_t                               head_req,
    output logic                                  empty,
    output logic                                  full,
    output logic [DEPTH-1:0]                      entry_valid,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]      entry_reg
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] c_FULL_COUNT = CNT_W'(DEPTH);

    wr_req_t            r_mem [DEPTH];
    logic [DEPTH-1:0]   r_valid;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_FULL_COUNT);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head_req  = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= '0;
        end else begin
            // Push and pop never hit the same slot: that needs empty or full.
            if (w_do_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_req;
        end
    end

    assign entry_valid = r_valid;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            assign entry_reg[i] = r_mem[i].rd;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Shares one register-file write port between WB and a queued MDU.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  wb_stall,
    input  logic                  mdu_valid,
    input  logic [REG_ADDR_W-1:0] mdu_reg,
    input  logic [DATA_W-1:0]     mdu_data,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] query_reg1,
    input  logic [REG_ADDR_W-1:0] query_reg2,
    output logic                  query_busy1,
    output logic                  query_busy2,
    output logic                  RegWrite,
    output logic [REG_ADDR_W-1:0] Write_register,
    output logic [DATA_W-1:0]     Write_data
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] c_STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic [STARVE_W-1:0]             r_starve_cnt;

    wr_req_t                         w_push_req;
    wr_req_t                         w_head_req;
    logic                            w_push;
    logic                            w_pop;
    logic                            w_empty;
    logic                            w_full;
    logic                            w_wb_win;
    logic [DEPTH-1:0]                w_entry_valid;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] w_entry_reg;

    assign mdu_ready       = !reset && !w_full;
    assign w_push          = mdu_valid && mdu_ready && (mdu_reg != '0);
    assign w_push_req.rd   = mdu_reg;
    assign w_push_req.data = mdu_data;

    rf_wr_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (w_push),
        .push_req    (w_push_req),
        .pop         (w_pop),
        .head_req    (w_head_req),
        .empty       (w_empty),
        .full        (w_full),
        .entry_valid (w_entry_valid),
        .entry_reg   (w_entry_reg)
    );

    assign wb_stall = !reset && !w_empty && (r_starve_cnt == c_STARVE_MAX);
    assign w_wb_win = !reset && !wb_stall && wb_valid;
    assign w_pop    = !reset && !w_wb_win && !w_empty;

    always_comb begin
        RegWrite       = 1'b0;
        Write_register = '0;
        Write_data     = '0;
        if (w_wb_win) begin
            // A write to r0 still consumes the port but is dropped.
            if (wb_reg != '0) begin
                RegWrite       = 1'b1;
                Write_register = wb_reg;
                Write_data     = wb_data;
            end
        end else if (w_pop) begin
            RegWrite       = 1'b1;
            Write_register = w_head_req.rd;
            Write_data     = w_head_req.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve_cnt <= '0;
        end else if (w_pop || w_empty) begin
            r_starve_cnt <= '0;
        end else if (w_wb_win && (r_starve_cnt != c_STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
        end
    end

    // The slot being popped this cycle is still valid, so it still blocks readers.
    always_comb begin
        query_busy1 = 1'b0;
        query_busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (reg_hit(w_entry_valid[i], w_entry_reg[i], query_reg1)) begin
                query_busy1 = 1'b1;
            end
            if (reg_hit(w_entry_valid[i], w_entry_reg[i], query_reg2)) begin
                query_busy2 = 1'b1;
            end
        end
        if (reset) begin
            query_busy1 = 1'b0;
            query_busy2 = 1'b0;
        end
    end

endmodule
`default_nettype wire
